// File: rtl/load_scoreboard_if.sv
// -----------------------------------------------------------------------------
// load_scoreboard_if
// Bundles the ID-stage, WB-stage and status signals exchanged between the
// pipeline control and the load scoreboard.
//   master : pipeline side (drives ID/WB/freeze/flush, observes stall/status)
//   slave  : scoreboard side
// Signals:
//   id_valid, id_src1, id_src2, id_two_src, id_dest, id_mem_read, id_wb_en
//   freeze, flush, wb_load_done, wb_dest                      (pipeline -> sb)
//   hazard_stall, busy, pend_vec, stall_cycles, err_underflow (sb -> pipeline)
// -----------------------------------------------------------------------------
interface load_scoreboard_if #(
    parameter int NREG   = 16,
    parameter int AW     = 4,
    parameter int PERF_W = 32
);
    logic              id_valid;
    logic [AW-1:0]     id_src1;
    logic [AW-1:0]     id_src2;
    logic              id_two_src;
    logic [AW-1:0]     id_dest;
    logic              id_mem_read;
    logic              id_wb_en;
    logic              freeze;
    logic              flush;
    logic              wb_load_done;
    logic [AW-1:0]     wb_dest;
    logic              hazard_stall;
    logic              busy;
    logic [NREG-1:0]   pend_vec;
    logic [PERF_W-1:0] stall_cycles;
    logic              err_underflow;

    modport master (
        output id_valid, id_src1, id_src2, id_two_src, id_dest, id_mem_read,
               id_wb_en, freeze, flush, wb_load_done, wb_dest,
        input  hazard_stall, busy, pend_vec, stall_cycles, err_underflow
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_two_src, id_dest, id_mem_read,
               id_wb_en, freeze, flush, wb_load_done, wb_dest,
        output hazard_stall, busy, pend_vec, stall_cycles, err_underflow
    );
endinterface

// File: rtl/load_scoreboard.sv
// -----------------------------------------------------------------------------
// load_scoreboard
// Counts in-flight SRAM loads per architectural register and stalls any ID
// instruction that reads a register whose load data has not yet reached WB.
// hazard_stall is combinational from the ID inputs and the registered counters
// and is ORed into the IF/ID freeze by the surrounding pipeline.
// Ports:
//   clk  : pipeline clock, rising edge
//   rst  : asynchronous, active-low reset
//   sb   : load_scoreboard_if.slave (ID/WB inputs, stall and status outputs)
// -----------------------------------------------------------------------------
module load_scoreboard #(
    parameter int NREG      = 16,
    parameter int AW        = 4,
    parameter int CNT_W     = 2,
    parameter bit WB_BYPASS = 1'b1,
    parameter int PERF_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    load_scoreboard_if.slave  sb
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [PERF_W-1:0] PERF_MAX = '1;

    // Saturating increment for the performance counter.
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == PERF_MAX) ? v : v + 1'b1;
    endfunction

    logic [CNT_W-1:0] cnt     [NREG];
    logic [CNT_W-1:0] cnt_nxt [NREG];
    logic [NREG-1:0]  pend_eff;
    logic [NREG-1:0]  pend_raw;
    logic             issue;
    logic             retire;
    logic             stall;
    logic             underflow;
    logic             full_dest;
    logic [PERF_W-1:0] stall_cycles_q;
    logic             err_q;

    // While frozen the WB stage is held, so its load is only counted once it moves.
    assign retire = sb.wb_load_done & ~sb.freeze;

    // Effective pending view used for stall decisions: with bypass, the last
    // outstanding load retiring this cycle is forwarded from WB.
    always_comb begin
        pend_raw = '0;
        pend_eff = '0;
        for (int r = 0; r < NREG; r++) begin
            pend_raw[r] = (cnt[r] != '0);
            pend_eff[r] = pend_raw[r];
            if (WB_BYPASS && retire && (sb.wb_dest == AW'(r)) && (cnt[r] == CNT_W'(1)))
                pend_eff[r] = 1'b0;
        end
    end

    // A further load to a saturated register must wait, so counters never wrap.
    assign full_dest = sb.id_mem_read & sb.id_wb_en & (cnt[sb.id_dest] == CNT_MAX);

    assign stall = sb.id_valid & ~sb.flush &
                   ( pend_eff[sb.id_src1]
                   | (sb.id_two_src & pend_eff[sb.id_src2])
                   | full_dest );

    assign issue = sb.id_valid & sb.id_mem_read & sb.id_wb_en &
                   ~stall & ~sb.freeze & ~sb.flush;

    // A same-register issue in the retire cycle covers a retire against zero.
    assign underflow = retire & (cnt[sb.wb_dest] == '0) &
                       ~(issue & (sb.id_dest == sb.wb_dest));

    always_comb begin
        cnt_nxt = cnt;
        for (int r = 0; r < NREG; r++) begin
            logic inc;
            logic dec;
            inc = issue  & (sb.id_dest == AW'(r));
            dec = retire & (sb.wb_dest == AW'(r));
            if (inc && !dec)
                cnt_nxt[r] = cnt[r] + 1'b1;
            else if (dec && !inc && (cnt[r] != '0))
                cnt_nxt[r] = cnt[r] - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++)
                cnt[r] <= '0;
            stall_cycles_q <= '0;
            err_q          <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++)
                cnt[r] <= cnt_nxt[r];
            if (stall)
                stall_cycles_q <= sat_inc(stall_cycles_q);
            if (underflow)
                err_q <= 1'b1;
        end
    end

    assign sb.hazard_stall  = stall;
    assign sb.pend_vec      = pend_raw;
    assign sb.busy          = |pend_raw;
    assign sb.stall_cycles  = stall_cycles_q;
    assign sb.err_underflow = err_q;

endmodule

// File: tb/tb_load_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_load_scoreboard
// Self-checking bench for load_scoreboard. A behavioural model of the
// per-register load counters predicts the outputs; predictions are queued when
// a cycle's stimulus is applied and popped when the DUT outputs are sampled.
// -----------------------------------------------------------------------------
module tb_load_scoreboard;

    localparam int NREG   = 16;
    localparam int AW     = 4;
    localparam int CNT_W  = 2;
    localparam int PERF_W = 32;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    load_scoreboard_if #(.NREG(NREG), .AW(AW), .PERF_W(PERF_W)) sb_if ();

    load_scoreboard #(
        .NREG(NREG), .AW(AW), .CNT_W(CNT_W), .WB_BYPASS(1'b1), .PERF_W(PERF_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if)
    );

    typedef struct {
        logic            stall;
        logic [NREG-1:0] pv;
        logic            busy;
        logic [31:0]     sc;
        logic            err;
    } exp_t;

    exp_t exp_q[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_cnt[NREG];
    logic [31:0] m_sc;
    bit          m_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
        m_sc  = 0;
        m_err = 0;
    endtask

    function automatic bit m_pend(input int r, input bit ret, input int wbd);
        if (m_cnt[r] == 0) return 0;
        if (ret && wbd == r && m_cnt[r] == 1) return 0;
        return 1;
    endfunction

    task automatic drive_idle();
        sb_if.id_valid     = 0;
        sb_if.id_src1      = '0;
        sb_if.id_src2      = '0;
        sb_if.id_two_src   = 0;
        sb_if.id_dest      = '0;
        sb_if.id_mem_read  = 0;
        sb_if.id_wb_en     = 0;
        sb_if.freeze       = 0;
        sb_if.flush        = 0;
        sb_if.wb_load_done = 0;
        sb_if.wb_dest      = '0;
    endtask

    // One pipeline cycle: apply inputs after the falling edge, predict, sample,
    // then advance the model across the rising edge.
    task automatic cycle(input string tag, input bit v, input int s1, input int s2,
                         input bit two, input int dst, input bit mr, input bit we,
                         input bit frz, input bit fl, input bit wld, input int wbd);
        exp_t e;
        bit   ret;
        bit   stl;
        bit   iss;
        @(negedge clk);
        sb_if.id_valid     = v;
        sb_if.id_src1      = AW'(s1);
        sb_if.id_src2      = AW'(s2);
        sb_if.id_two_src   = two;
        sb_if.id_dest      = AW'(dst);
        sb_if.id_mem_read  = mr;
        sb_if.id_wb_en     = we;
        sb_if.freeze       = frz;
        sb_if.flush        = fl;
        sb_if.wb_load_done = wld;
        sb_if.wb_dest      = AW'(wbd);
        ret = wld && !frz;
        stl = v && !fl && (m_pend(s1, ret, wbd) || (two && m_pend(s2, ret, wbd)) ||
                           (mr && we && m_cnt[dst] == MAXC));
        e.stall = stl;
        e.pv    = '0;
        for (int r = 0; r < NREG; r++) e.pv[r] = (m_cnt[r] != 0);
        e.busy  = |e.pv;
        e.sc    = m_sc;
        e.err   = m_err;
        exp_q.push_back(e);
        #1;
        e = exp_q.pop_front();
        check({tag, ".stall"}, 64'(sb_if.hazard_stall), 64'(e.stall));
        check({tag, ".pend_vec"}, 64'(sb_if.pend_vec), 64'(e.pv));
        check({tag, ".busy"}, 64'(sb_if.busy), 64'(e.busy));
        check({tag, ".stall_cycles"}, 64'(sb_if.stall_cycles), 64'(e.sc));
        check({tag, ".err"}, 64'(sb_if.err_underflow), 64'(e.err));
        @(posedge clk);
        iss = v && mr && we && !stl && !frz && !fl;
        if (stl && m_sc != 32'hFFFF_FFFF) m_sc++;
        if (ret) begin
            if (m_cnt[wbd] == 0 && !(iss && dst == wbd)) m_err = 1;
            else m_cnt[wbd]--;
        end
        if (iss) m_cnt[dst]++;
    endtask

    // Shorthands: load, reader, retire-only, idle.
    task automatic ldr(input string tag, input int dst, input bit wld = 0, input int wbd = 0);
        cycle(tag, 1, 0, 0, 0, dst, 1, 1, 0, 0, wld, wbd);
    endtask

    task automatic rd(input string tag, input int s1, input bit wld = 0, input int wbd = 0,
                      input bit frz = 0);
        cycle(tag, 1, s1, 0, 0, 4, 0, 1, frz, 0, wld, wbd);
    endtask

    task automatic idle(input string tag, input bit wld = 0, input int wbd = 0,
                        input bit frz = 0);
        cycle(tag, 0, 0, 0, 0, 0, 0, 0, frz, 0, wld, wbd);
    endtask

    initial begin
        model_reset();
        drive_idle();
        #12;
        check("rst.stall", 64'(sb_if.hazard_stall), 64'd0);
        check("rst.pend_vec", 64'(sb_if.pend_vec), 64'd0);
        check("rst.stall_cycles", 64'(sb_if.stall_cycles), 64'd0);
        check("rst.err", 64'(sb_if.err_underflow), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Load-use on R3 with WB bypass; second source unused then used.
        ldr("t1.ldr", 3);
        rd("t1.use0", 3);
        rd("t1.use1", 3);
        cycle("t1.use2_two", 1, 0, 3, 1, 4, 0, 1, 0, 0, 0, 0);
        rd("t1.use_wb", 3, 1, 3);
        idle("t1.done");
        check("t1.stall_cycles", 64'(sb_if.stall_cycles), 64'd3);

        // Same-cycle issue and retire of R5.
        ldr("t2.ldr", 5);
        ldr("t2.both", 5, 1, 5);
        idle("t2.hold");
        check("t2.pend5", 64'(sb_if.pend_vec[5]), 64'd1);
        idle("t2.drain", 1, 5);

        // Three loads to R2 saturate; the fourth waits for a retire.
        ldr("t3.l1", 2);
        ldr("t3.l2", 2);
        ldr("t3.l3", 2);
        ldr("t3.l4_full", 2);
        ldr("t3.l4_ret", 2, 1, 2);
        ldr("t3.l4_issue", 2);
        ldr("t3.l5_full", 2);
        idle("t3.d1", 1, 2);
        idle("t3.d2", 1, 2);
        idle("t3.d3", 1, 2);

        // Freeze holds the WB retire of R7; stall is not gated by freeze.
        ldr("t4.ldr", 7);
        for (int i = 0; i < 4; i++) rd($sformatf("t4.frz%0d", i), 7, 1, 7, 1);
        idle("t4.unfrz", 1, 7);
        idle("t4.after");

        // Underflow on R9 is sticky; flushed load neither issues nor stalls.
        idle("t5.under", 1, 9);
        cycle("t5.flush", 1, 0, 0, 0, 6, 1, 1, 0, 1, 0, 0);
        idle("t5.after");
        ldr("t5.ldr15", 15);
        cycle("t5.flush_rd", 1, 15, 0, 0, 4, 0, 1, 0, 1, 1, 15);
        idle("t5.end");

        // Asynchronous reset mid-cycle with R1 pending twice and a stall active.
        ldr("t6.l1", 1);
        ldr("t6.l2", 1);
        @(negedge clk);
        sb_if.id_valid = 1; sb_if.id_src1 = AW'(1); sb_if.id_mem_read = 0;
        sb_if.id_wb_en = 1; sb_if.id_dest = AW'(4);
        #1;
        check("t6.pre_stall", 64'(sb_if.hazard_stall), 64'd1);
        #1;
        rst = 1'b0;
        #1;
        check("t6.rst_stall", 64'(sb_if.hazard_stall), 64'd0);
        check("t6.rst_busy", 64'(sb_if.busy), 64'd0);
        check("t6.rst_pend", 64'(sb_if.pend_vec), 64'd0);
        check("t6.rst_sc", 64'(sb_if.stall_cycles), 64'd0);
        check("t6.rst_err", 64'(sb_if.err_underflow), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        rd("t6.after", 1);
        idle("t6.end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
